// File: rtl/cache_l1_assoc_ctrl.sv
// L1 data-cache controller: N-way set-associative, write-back, write-allocate, age-based LRU.
// Serves one processor ID; a miss writes back a dirty victim first, then refills the line from L2.
module cache_l1_assoc_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 2,
    parameter int CORE_ID  = 1,
    parameter int WORD_W   = 32,
    parameter int LINE_W   = 128,
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              hit,
    output logic              miss,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rd_req,
    input  logic              l2_rd_valid,
    input  logic [LINE_W-1:0] l2_rd_data,
    output logic              l2_wb_req,
    output logic [LINE_W-1:0] l2_wb_data,
    input  logic              l2_wb_ack
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int WPL    = LINE_W / WORD_W;
    localparam int WSEL_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - ID_W - IDX_W - OFF_W;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITE_BACK,
        S_REFILL,
        S_RESPOND
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic [WAY_W-1:0]  r_victim;

    logic [TAG_W-1:0]  r_tag   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] r_data  [NUM_SETS][NUM_WAYS];
    logic              r_valid [NUM_SETS][NUM_WAYS];
    logic              r_dirty [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  r_age   [NUM_SETS][NUM_WAYS];

    logic              w_reqMine;
    logic [ID_W-1:0]   w_id;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WSEL_W-1:0] w_wsel;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hitWay;
    logic [WAY_W-1:0]  w_victim;
    logic              w_victimDirty;
    logic [WAY_W-1:0]  w_accWay;
    logic [WAY_W-1:0]  w_newAge [NUM_WAYS];
    logic [LINE_W-1:0] w_hitLine;
    logic [LINE_W-1:0] w_victimLine;
    logic [TAG_W-1:0]  w_victimTag;
    logic [LINE_W-1:0] w_fillLine;
    logic [WORD_W-1:0] w_hitWord;
    logic [WORD_W-1:0] w_fillWord;
    logic              w_unusedAddr;

    function automatic logic [LINE_W-1:0] mergeWord(input logic [LINE_W-1:0] line,
                                                    input logic [WSEL_W-1:0] sel,
                                                    input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] res;
        res = line;
        res[sel*WORD_W +: WORD_W] = word;
        return res;
    endfunction

    assign w_reqMine = (req_addr[ADDR_W-1 -: ID_W] == ID_W'(CORE_ID));
    assign w_id      = r_addr[ADDR_W-1 -: ID_W];
    assign w_idx     = r_addr[OFF_W +: IDX_W];
    assign w_tag     = r_addr[OFF_W+IDX_W +: TAG_W];
    // Byte-within-word address bits never select data; folded here so the whole latch is consumed.
    assign w_unusedAddr = ^r_addr;

    generate
        if (WPL > 1) begin : g_wsel
            assign w_wsel = r_addr[BYTE_W +: WSEL_W];
        end else begin : g_noWsel
            assign w_wsel = '0;
        end
    endgenerate

    // Tag compare across the set, plus victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        w_victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_age[w_idx][w] == WAY_W'(NUM_WAYS - 1)) w_victim = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
        end
    end

    assign w_victimDirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
    assign w_hitLine     = r_data[w_idx][w_hitWay];
    assign w_victimLine  = r_data[w_idx][r_victim];
    assign w_victimTag   = r_tag[w_idx][r_victim];
    assign w_hitWord     = w_hitLine[w_wsel*WORD_W +: WORD_W];
    assign w_fillWord    = l2_rd_data[w_wsel*WORD_W +: WORD_W];
    assign w_fillLine    = r_write ? mergeWord(l2_rd_data, w_wsel, r_wdata) : l2_rd_data;
    assign w_accWay      = (r_state == S_LOOKUP) ? w_hitWay : r_victim;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_newAge[w] = r_age[w_idx][w];
            if (WAY_W'(w) == w_accWay) begin
                w_newAge[w] = '0;
            end else if (r_age[w_idx][w] < r_age[w_idx][w_accWay]) begin
                w_newAge[w] = r_age[w_idx][w] + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        hit         = 1'b0;
        miss        = 1'b0;
        l2_addr     = '0;
        l2_rd_req   = 1'b0;
        l2_wb_req   = 1'b0;
        l2_wb_data  = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && w_reqMine) w_nextState = S_LOOKUP;
            end
            S_LOOKUP: begin
                hit  = w_hit;
                miss = !w_hit;
                if (w_hit)              w_nextState = S_RESPOND;
                else if (w_victimDirty) w_nextState = S_WRITE_BACK;
                else                    w_nextState = S_REFILL;
            end
            S_WRITE_BACK: begin
                l2_wb_req  = 1'b1;
                l2_wb_data = w_victimLine;
                l2_addr    = {w_id, w_victimTag, w_idx, {OFF_W{1'b0}}};
                if (l2_wb_ack) w_nextState = S_REFILL;
            end
            S_REFILL: begin
                l2_rd_req = 1'b1;
                l2_addr   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (l2_rd_valid) w_nextState = S_RESPOND;
            end
            S_RESPOND: begin
                resp_valid  = 1'b1;
                resp_rdata  = r_rdata;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_victim <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_reqMine) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                    end
                end
                S_LOOKUP: begin
                    r_victim <= w_victim;
                    if (w_hit) begin
                        r_rdata <= r_write ? '0 : w_hitWord;
                        if (r_write) r_dirty[w_idx][w_hitWay] <= 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++) r_age[w_idx][w] <= w_newAge[w];
                    end
                end
                S_WRITE_BACK: begin
                    if (l2_wb_ack) r_dirty[w_idx][r_victim] <= 1'b0;
                end
                S_REFILL: begin
                    if (l2_rd_valid) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= r_write;
                        r_rdata <= r_write ? '0 : w_fillWord;
                        for (int w = 0; w < NUM_WAYS; w++) r_age[w_idx][w] <= w_newAge[w];
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data and tags need no reset: a line is only ever read once its valid bit is set.
    always_ff @(posedge clk) begin
        if ((r_state == S_LOOKUP) && w_hit && r_write) begin
            r_data[w_idx][w_hitWay] <= mergeWord(w_hitLine, w_wsel, r_wdata);
        end
        if ((r_state == S_REFILL) && l2_rd_valid) begin
            r_data[w_idx][r_victim] <= w_fillLine;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end
endmodule

// File: tb/tb_cache_l1_assoc_ctrl.sv
// Bench for cache_l1_assoc_ctrl: directed scenarios plus random traffic scored against
// a recency-list cache model and a sparse L2 memory model.
module tb_cache_l1_assoc_ctrl;
    localparam int ADDR_W   = 32;
    localparam int ID_W     = 2;
    localparam int CORE_ID  = 1;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;
    localparam int NUM_SETS = 16;
    localparam int NUM_WAYS = 2;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              hit;
    logic              miss;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_rd_req;
    logic              l2_rd_valid;
    logic [LINE_W-1:0] l2_rd_data;
    logic              l2_wb_req;
    logic [LINE_W-1:0] l2_wb_data;
    logic              l2_wb_ack;

    cache_l1_assoc_ctrl #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .CORE_ID(CORE_ID), .WORD_W(WORD_W),
        .LINE_W(LINE_W), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .hit(hit), .miss(miss),
        .l2_addr(l2_addr), .l2_rd_req(l2_rd_req), .l2_rd_valid(l2_rd_valid),
        .l2_rd_data(l2_rd_data), .l2_wb_req(l2_wb_req), .l2_wb_data(l2_wb_data),
        .l2_wb_ack(l2_wb_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // L2 memory model and responder knobs / observations
    logic [LINE_W-1:0] l2mem [logic [ADDR_W-1:0]];
    int rdWait = 0, wbWait = 0, rdCnt = 0, wbCnt = 0, rdSeen = 0, wbSeen = 0;
    bit holdWb = 1'b0;
    logic [ADDR_W-1:0] lastRdAddr, lastWbAddr;
    logic [LINE_W-1:0] lastWbData;

    // Cache reference model: per-set recency list, front = most recently used
    bit                mValid [NUM_SETS][NUM_WAYS];
    bit                mDirty [NUM_SETS][NUM_WAYS];
    logic [21:0]       mTag   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] mLine  [NUM_SETS][NUM_WAYS];
    int                mOrder [NUM_SETS][$];
    bit                expHit, expWb;
    logic [WORD_W-1:0] expRdata;
    logic [ADDR_W-1:0] expWbAddr, expRdAddr;
    logic [LINE_W-1:0] expWbData;

    // Observations from one transaction
    int                obsHits, obsMisses, obsLat, obsRd, obsWb;
    logic [WORD_W-1:0] obsRdata;

    function automatic logic [LINE_W-1:0] getLine(input logic [ADDR_W-1:0] la);
        if (!l2mem.exists(la)) l2mem[la] = {$urandom, $urandom, $urandom, $urandom};
        return l2mem[la];
    endfunction

    function automatic int expLatency();
        if (expHit) return 2;
        return 3 + rdWait + (expWb ? wbWait + 1 : 0);
    endfunction

    initial begin
        l2_rd_valid = 1'b0;
        l2_wb_ack   = 1'b0;
        l2_rd_data  = '0;
        forever begin
            @(negedge clk);
            l2_rd_valid = 1'b0;
            l2_wb_ack   = 1'b0;
            if (l2_wb_req && !reset) begin
                if (wbCnt >= wbWait && !holdWb) begin
                    l2_wb_ack  = 1'b1;
                    wbSeen++;
                    lastWbAddr = l2_addr;
                    lastWbData = l2_wb_data;
                    wbCnt      = 0;
                end else wbCnt++;
            end else wbCnt = 0;
            if (l2_rd_req && !reset) begin
                if (rdCnt >= rdWait) begin
                    l2_rd_valid = 1'b1;
                    l2_rd_data  = getLine(l2_addr);
                    rdSeen++;
                    lastRdAddr  = l2_addr;
                    rdCnt       = 0;
                end else rdCnt++;
            end else rdCnt = 0;
        end
    end

    task automatic model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            mOrder[s].delete();
            for (int w = 0; w < NUM_WAYS; w++) begin
                mValid[s][w] = 1'b0;
                mDirty[s][w] = 1'b0;
                mOrder[s].push_back(w);
            end
        end
    endtask

    task automatic model_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        int s, way, pos, ws;
        logic [21:0] t;
        logic [ADDR_W-1:0] la;
        s   = int'(a[7:4]);
        t   = a[29:8];
        ws  = int'(a[3:2]);
        la  = {a[31:4], 4'b0};
        way = -1;
        pos = 0;
        expWb = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) if (mValid[s][i] && mTag[s][i] == t) way = i;
        expHit = (way >= 0);
        if (!expHit) begin
            for (int i = NUM_WAYS - 1; i >= 0; i--) if (!mValid[s][i]) way = i;
            if (way < 0) way = mOrder[s][$];
            if (mValid[s][way] && mDirty[s][way]) begin
                expWb     = 1'b1;
                expWbAddr = {a[31:30], mTag[s][way], 4'(s), 4'b0};
                expWbData = mLine[s][way];
                l2mem[expWbAddr] = mLine[s][way];
            end
            mLine[s][way]  = getLine(la);
            mValid[s][way] = 1'b1;
            mTag[s][way]   = t;
            mDirty[s][way] = 1'b0;
            expRdAddr      = la;
        end
        for (int i = 0; i < mOrder[s].size(); i++) if (mOrder[s][i] == way) pos = i;
        mOrder[s].delete(pos);
        mOrder[s].push_front(way);
        if (wr) begin
            mLine[s][way][ws*32 +: 32] = d;
            mDirty[s][way] = 1'b1;
            expRdata = '0;
        end else expRdata = mLine[s][way][ws*32 +: 32];
    endtask

    task automatic run_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        int rd0, wb0, n;
        rd0 = rdSeen;
        wb0 = wbSeen;
        obsHits = 0; obsMisses = 0; obsLat = -1; obsRdata = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        for (int c = 1; c <= 200 && obsLat < 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (hit)  obsHits++;
            if (miss) obsMisses++;
            if (resp_valid) begin
                obsLat   = c;
                obsRdata = resp_rdata;
            end
        end
        obsRd = rdSeen - rd0;
        obsWb = wbSeen - wb0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
        total++;
        if ({resp_valid, hit, miss, l2_rd_req, l2_wb_req} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_pulses: got %b want 00000", {resp_valid, hit, miss, l2_rd_req, l2_wb_req});
        end
        total++;
        if (l2_addr !== '0 || resp_rdata !== '0 || l2_wb_data !== '0) begin
            bad++; $display("[TB] FAIL reset_buses: l2_addr=%h rdata=%h wb_data=%h want 0", l2_addr, resp_rdata, l2_wb_data);
        end
    endtask

    task automatic test_cold_load();
        l2mem[32'h4000_0010] = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
        rdWait = 1; wbWait = 0;
        model_access(1'b0, 32'h4000_0010, '0);
        run_req(1'b0, 32'h4000_0010, '0);
        total++;
        if (obsMisses !== 1 || obsHits !== 0) begin bad++; $display("[TB] FAIL cold_miss: hits=%0d misses=%0d want 0/1", obsHits, obsMisses); end
        total++;
        if (obsRdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL cold_rdata: got %h want deadbeef", obsRdata); end
        total++;
        if (obsRd !== 1 || lastRdAddr !== 32'h4000_0010) begin bad++; $display("[TB] FAIL cold_refill: reads=%0d addr=%h want 1/40000010", obsRd, lastRdAddr); end
        total++;
        if (obsWb !== 0) begin bad++; $display("[TB] FAIL cold_no_wb: got %0d want 0", obsWb); end
        total++;
        if (obsLat !== expLatency()) begin bad++; $display("[TB] FAIL cold_latency: got %0d want %0d", obsLat, expLatency()); end
    endtask

    task automatic test_hit_repeat();
        model_access(1'b0, 32'h4000_0010, '0);
        run_req(1'b0, 32'h4000_0010, '0);
        total++;
        if (obsHits !== 1 || obsMisses !== 0) begin bad++; $display("[TB] FAIL hit_pulse: hits=%0d misses=%0d want 1/0", obsHits, obsMisses); end
        total++;
        if (obsLat !== 2) begin bad++; $display("[TB] FAIL hit_latency: got %0d want 2", obsLat); end
        total++;
        if (obsRd !== 0 || obsWb !== 0) begin bad++; $display("[TB] FAIL hit_no_l2: reads=%0d wbs=%0d want 0/0", obsRd, obsWb); end
        total++;
        if (obsRdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL hit_rdata: got %h want deadbeef", obsRdata); end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL resp_one_cycle: got %b want 0", resp_valid); end
    endtask

    task automatic test_store_hit();
        model_access(1'b1, 32'h4000_0014, 32'hCAFEF00D);
        run_req(1'b1, 32'h4000_0014, 32'hCAFEF00D);
        total++;
        if (obsHits !== 1 || obsLat !== 2) begin bad++; $display("[TB] FAIL store_hit: hits=%0d lat=%0d want 1/2", obsHits, obsLat); end
        total++;
        if (obsRdata !== '0) begin bad++; $display("[TB] FAIL store_rdata: got %h want 0", obsRdata); end
        model_access(1'b0, 32'h4000_0014, '0);
        run_req(1'b0, 32'h4000_0014, '0);
        total++;
        if (obsRdata !== 32'hCAFEF00D || obsHits !== 1) begin bad++; $display("[TB] FAIL store_readback: got %h hits=%0d want cafef00d/1", obsRdata, obsHits); end
    endtask

    task automatic test_dirty_evict();
        rdWait = 0; wbWait = 2;
        model_access(1'b0, 32'h4000_1010, '0);
        run_req(1'b0, 32'h4000_1010, '0);
        total++;
        if (obsMisses !== 1 || obsWb !== 0) begin bad++; $display("[TB] FAIL evict_fill2: misses=%0d wbs=%0d want 1/0", obsMisses, obsWb); end
        model_access(1'b0, 32'h4000_1010, '0);
        run_req(1'b0, 32'h4000_1010, '0);
        total++;
        if (obsHits !== 1) begin bad++; $display("[TB] FAIL evict_touch: hits=%0d want 1", obsHits); end
        model_access(1'b0, 32'h4000_2010, '0);
        run_req(1'b0, 32'h4000_2010, '0);
        total++;
        if (obsWb !== 1 || lastWbAddr !== 32'h4000_0010) begin bad++; $display("[TB] FAIL evict_wb_addr: wbs=%0d addr=%h want 1/40000010", obsWb, lastWbAddr); end
        total++;
        if (lastWbData[63:32] !== 32'hCAFEF00D || lastWbData !== expWbData) begin
            bad++; $display("[TB] FAIL evict_wb_data: got %h want %h", lastWbData, expWbData);
        end
        total++;
        if (obsRd !== 1 || lastRdAddr !== 32'h4000_2010 || obsRdata !== expRdata) begin
            bad++; $display("[TB] FAIL evict_refill: reads=%0d addr=%h rdata=%h want 1/40002010/%h", obsRd, lastRdAddr, obsRdata, expRdata);
        end
        total++;
        if (obsLat !== expLatency()) begin bad++; $display("[TB] FAIL evict_latency: got %0d want %0d", obsLat, expLatency()); end
        model_access(1'b0, 32'h4000_0014, '0);
        run_req(1'b0, 32'h4000_0014, '0);
        total++;
        if (obsMisses !== 1 || obsRdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL evict_reload: misses=%0d rdata=%h want 1/cafef00d", obsMisses, obsRdata); end
    endtask

    task automatic test_foreign_id();
        int rd0, wb0;
        rd0 = rdSeen;
        wb0 = wbSeen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0010;
        repeat (6) begin
            @(negedge clk);
            total++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || hit !== 1'b0 || miss !== 1'b0 || l2_rd_req !== 1'b0 || l2_wb_req !== 1'b0) begin
                bad++; $display("[TB] FAIL foreign_idle: ready=%b resp=%b hit=%b miss=%b rd=%b wb=%b want 1/0/0/0/0/0",
                                req_ready, resp_valid, hit, miss, l2_rd_req, l2_wb_req);
            end
        end
        req_valid = 1'b0;
        total++;
        if (rdSeen != rd0 || wbSeen != wb0) begin bad++; $display("[TB] FAIL foreign_l2: reads=%0d wbs=%0d want 0/0", rdSeen - rd0, wbSeen - wb0); end
    endtask

    task automatic test_random();
        bit wr;
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = {2'b01, 22'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            d  = $urandom;
            rdWait = $urandom_range(0, 3);
            wbWait = $urandom_range(0, 3);
            model_access(wr, a, d);
            run_req(wr, a, d);
            total++;
            if (obsHits !== int'(expHit) || obsMisses !== int'(!expHit)) begin
                bad++; $display("[TB] FAIL rnd_hitmiss #%0d: hits=%0d misses=%0d want hit=%0b", i, obsHits, obsMisses, expHit);
            end
            total++;
            if (obsRdata !== expRdata) begin bad++; $display("[TB] FAIL rnd_rdata #%0d: got %h want %h", i, obsRdata, expRdata); end
            total++;
            if (obsLat !== expLatency()) begin bad++; $display("[TB] FAIL rnd_latency #%0d: got %0d want %0d", i, obsLat, expLatency()); end
            total++;
            if (obsWb !== int'(expWb) || obsRd !== int'(!expHit)) begin
                bad++; $display("[TB] FAIL rnd_l2count #%0d: wbs=%0d reads=%0d want %0d/%0d", i, obsWb, obsRd, expWb, !expHit);
            end
            if (expWb) begin
                total++;
                if (lastWbAddr !== expWbAddr || lastWbData !== expWbData) begin
                    bad++; $display("[TB] FAIL rnd_wb #%0d: addr=%h data=%h want %h/%h", i, lastWbAddr, lastWbData, expWbAddr, expWbData);
                end
            end
            if (!expHit) begin
                total++;
                if (lastRdAddr !== expRdAddr) begin bad++; $display("[TB] FAIL rnd_rdaddr #%0d: got %h want %h", i, lastRdAddr, expRdAddr); end
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        bit seen;
        rdWait = 0; wbWait = 0;
        model_access(1'b1, 32'h4001_0050, 32'h1111_2222);
        run_req(1'b1, 32'h4001_0050, 32'h1111_2222);
        model_access(1'b1, 32'h4001_0150, 32'h3333_4444);
        run_req(1'b1, 32'h4001_0150, 32'h3333_4444);
        total++;
        if (obsMisses !== 1 || obsWb !== 0) begin bad++; $display("[TB] FAIL rstwb_setup: misses=%0d wbs=%0d want 1/0", obsMisses, obsWb); end
        holdWb = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4001_0250;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (l2_wb_req) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL rstwb_wb_req: got 0 want 1"); end
        reset = 1'b1;
        #1;
        total++;
        if (l2_wb_req !== 1'b0 || l2_rd_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rstwb_abort: wb=%b rd=%b ready=%b resp=%b want 0/0/1/0", l2_wb_req, l2_rd_req, req_ready, resp_valid);
        end
        @(negedge clk);
        reset  = 1'b0;
        holdWb = 1'b0;
        model_reset();
        model_access(1'b0, 32'h4000_0014, '0);
        run_req(1'b0, 32'h4000_0014, '0);
        total++;
        if (obsMisses !== 1 || obsHits !== 0 || obsRdata !== expRdata) begin
            bad++; $display("[TB] FAIL rstwb_relo: misses=%0d hits=%0d rdata=%h want 1/0/%h", obsMisses, obsHits, obsRdata, expRdata);
        end
        model_access(1'b0, 32'h4001_0050, '0);
        run_req(1'b0, 32'h4001_0050, '0);
        total++;
        if (obsMisses !== 1 || obsRdata !== expRdata) begin
            bad++; $display("[TB] FAIL rstwb_lost_dirty: misses=%0d rdata=%h want 1/%h", obsMisses, obsRdata, expRdata);
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_hit_repeat();
        test_store_hit();
        test_dirty_evict();
        test_foreign_id();
        test_random();
        test_reset_mid_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
